// File: rtl/line_backing_mem.sv
// line_backing_mem
// Line-granular backing memory that models main memory for the cache
// controller. It accepts one line read or one line write per handshake and
// answers after a fixed LATENCY: a read gives a one-cycle is_output_valid
// pulse with the line on dout, and a write gives a one-cycle is_write_done
// pulse.
//
// Ports
//   clk              single clock, rising edge
//   reset            asynchronous, active-low reset
//   is_input_valid   request present
//   addr[31:0]       line address; only the low CLOG2(NUM_BLOCKS) bits are used
//   mem_read         request is a line read
//   mem_write        request is a line write
//   din              line write data (BLOCK_SIZE*8 bits)
//   is_output_valid  read data valid on dout, one-cycle pulse
//   is_write_done    write committed, one-cycle pulse
//   dout             read line data, forced to 0 when no read response is shown
//   mem_ready        block can accept a request this cycle
//   num_reads        completed reads   (only with LINE_MEM_STATS_EN)
//   num_writes       completed writes  (only with LINE_MEM_STATS_EN)
//
// Build option: define LINE_MEM_STATS_EN to add the completed-operation
// counters. Without it the counter ports and their logic do not exist.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | mem_ready high; waiting for a read xor write request
// BUSY  | request latched; countdown running toward the response
// RESP  | one-cycle response; a read drives dout, a write commits
module line_backing_mem #(
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_BLOCKS = 256,
   parameter int LATENCY    = 50
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    is_input_valid,
   input  logic [31:0]             addr,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [BLOCK_SIZE*8-1:0] din,
   output logic                    is_output_valid,
   output logic                    is_write_done,
   output logic [BLOCK_SIZE*8-1:0] dout,
`ifdef LINE_MEM_STATS_EN
   output logic                    mem_ready,
   output logic [31:0]             num_reads,
   output logic [31:0]             num_writes
`else
   output logic                    mem_ready
`endif
);

   localparam int W     = BLOCK_SIZE * 8;
   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int CNT_W = $clog2(LATENCY) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               load;
   logic               op_rd;
   logic [IDX_W-1:0]   idx;
   logic [W-1:0]       din_q;
   logic [W-1:0]       mem [NUM_BLOCKS];

   // Upper line-address bits wrap away by design.
   logic unused_addr;
   assign unused_addr = ^addr[31:IDX_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         count <= '0;
         op_rd <= 1'b0;
         idx   <= '0;
         din_q <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (load) begin
            op_rd <= mem_read;
            idx   <= addr[IDX_W-1:0];
            din_q <= din;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            // Exactly one of read/write must be set; anything else is a no-op.
            if (is_input_valid && (mem_read ^ mem_write)) begin
               load      = 1'b1;
               count_nxt = CNT_W'(LATENCY - 1);
               state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
            end
         end
         S_BUSY: begin
            // The count reaches 0 on the same edge that enters RESP, which
            // puts the response LATENCY-1 edges after acceptance.
            count_nxt = (count == '0) ? '0 : count - 1'b1;
            if (count <= CNT_W'(1)) state_nxt = S_RESP;
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            count_nxt = '0;
         end
      endcase
   end

   // Storage has no reset; an aborted write never reaches RESP, so it is
   // dropped without touching the array.
   always_ff @(posedge clk) begin
      if (state == S_RESP && !op_rd) mem[idx] <= din_q;
   end

   assign mem_ready       = (state == S_IDLE);
   assign is_output_valid = (state == S_RESP) && op_rd;
   assign is_write_done   = (state == S_RESP) && !op_rd;
   assign dout            = is_output_valid ? mem[idx] : '0;

`ifdef LINE_MEM_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_reads  <= '0;
         num_writes <= '0;
      end else if (state == S_RESP) begin
         if (op_rd) num_reads  <= num_reads + 32'd1;
         else       num_writes <= num_writes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_line_backing_mem.sv
module tb_line_backing_mem;

   localparam int BS   = 16;
   localparam int W    = BS * 8;
   localparam int NB   = 256;
   localparam int LAT  = 50;
   localparam int NB1  = 16;
   localparam int LAT1 = 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT 0: default LATENCY=50, NUM_BLOCKS=256
   logic         iv0 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
   logic [31:0]  addr0 = '0;
   logic [W-1:0] din0 = '0;
   logic         ov0, wd0, rdy0;
   logic [W-1:0] dout0;
   // DUT 1: LATENCY=1, NUM_BLOCKS=16
   logic         iv1 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0]  addr1 = '0;
   logic [W-1:0] din1 = '0;
   logic         ov1, wd1, rdy1;
   logic [W-1:0] dout1;
`ifdef LINE_MEM_STATS_EN
   logic [31:0]  nr0, nw0, nr1, nw1;
`endif

   line_backing_mem #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .is_input_valid(iv0), .addr(addr0),
      .mem_read(rd0), .mem_write(wr0), .din(din0),
      .is_output_valid(ov0), .is_write_done(wd0), .dout(dout0),
`ifdef LINE_MEM_STATS_EN
      .mem_ready(rdy0), .num_reads(nr0), .num_writes(nw0)
`else
      .mem_ready(rdy0)
`endif
   );

   line_backing_mem #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB1), .LATENCY(LAT1)) dut1 (
      .clk(clk), .reset(reset), .is_input_valid(iv1), .addr(addr1),
      .mem_read(rd1), .mem_write(wr1), .din(din1),
      .is_output_valid(ov1), .is_write_done(wd1), .dout(dout1),
`ifdef LINE_MEM_STATS_EN
      .mem_ready(rdy1), .num_reads(nr1), .num_writes(nw1)
`else
      .mem_ready(rdy1)
`endif
   );

   typedef struct {
      bit           is_rd;
      logic [W-1:0] data;
      int           due;
   } exp_t;

   exp_t         q0[$], q1[$];
   logic [W-1:0] model0 [NB];
   logic [W-1:0] model1 [NB1];
   int           rd_exp0 = 0, wr_exp0 = 0, rd_exp1 = 0, wr_exp1 = 0;
   int           errors = 0, checks = 0;

   task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitors: compare every response pulse against the scoreboard queues.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (ov0 && wd0) chk("both_pulses0", 1, 0);
         if (!ov0) chk("dout_idle0", dout0, 0);
         if (ov0 || wd0) begin
            if (q0.size() == 0) chk("unexpected_resp0", 1, 0);
            else begin
               e = q0.pop_front();
               chk("resp_kind0", ov0, e.is_rd);
               chk("resp_time0", cyc, e.due);
               if (ov0) chk("rdata0", dout0, e.data);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (ov1 && wd1) chk("both_pulses1", 1, 0);
         if (!ov1) chk("dout_idle1", dout1, 0);
         if (ov1 || wd1) begin
            if (q1.size() == 0) chk("unexpected_resp1", 1, 0);
            else begin
               e = q1.pop_front();
               chk("resp_kind1", ov1, e.is_rd);
               chk("resp_time1", cyc, e.due);
               if (ov1) chk("rdata1", dout1, e.data);
            end
         end
      end
   end

   function automatic logic [W-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge. Issues one request, then waits until the block is
   // ready again and checks how long it stayed busy.
   task automatic issue0(bit r, bit w, logic [31:0] a, logic [W-1:0] d);
      int   n;
      exp_t e;
      n = 0;
      while (!rdy0 && n < 2000) begin @(negedge clk); n++; end
      if (!rdy0) begin chk("ready_timeout0", 0, 1); return; end
      iv0 = 1'b1; rd0 = r; wr0 = w; addr0 = a; din0 = d;
      if (r ^ w) begin
         if (w) begin model0[a % NB] = d; wr_exp0++; end
         else rd_exp0++;
         e.is_rd = r; e.data = model0[a % NB]; e.due = cyc + LAT;
         q0.push_back(e);
      end
      @(negedge clk);
      iv0 = 1'b0; rd0 = 1'($urandom); wr0 = 1'($urandom);
      addr0 = $urandom; din0 = rnd_line();
      if (r ^ w) begin
         n = 1;
         while (!rdy0 && n < 2000) begin @(negedge clk); n++; end
         chk("busy_span0", n, LAT + 1);
      end else begin
         chk("noop_ready0", rdy0, 1);
      end
   endtask

   task automatic issue1(bit r, bit w, logic [31:0] a, logic [W-1:0] d);
      int   n;
      exp_t e;
      n = 0;
      while (!rdy1 && n < 100) begin @(negedge clk); n++; end
      if (!rdy1) begin chk("ready_timeout1", 0, 1); return; end
      iv1 = 1'b1; rd1 = r; wr1 = w; addr1 = a; din1 = d;
      if (r ^ w) begin
         if (w) begin model1[a % NB1] = d; wr_exp1++; end
         else rd_exp1++;
         e.is_rd = r; e.data = model1[a % NB1]; e.due = cyc + LAT1;
         q1.push_back(e);
      end
      @(negedge clk);
      iv1 = 1'b0; addr1 = $urandom; din1 = rnd_line();
      if (r ^ w) begin
         n = 1;
         while (!rdy1 && n < 100) begin @(negedge clk); n++; end
         chk("busy_span1", n, LAT1 + 1);
      end else begin
         chk("noop_ready1", rdy1, 1);
      end
   endtask

   initial begin
      logic [W-1:0] a5;
      logic [W-1:0] d;
      int           op;

      for (int i = 0; i < NB; i++)  model0[i] = '0;
      for (int i = 0; i < NB1; i++) model1[i] = '0;
      a5 = {16{8'hA5}};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", rdy0, 1);
      chk("rst_valid", ov0, 0);
      chk("rst_done", wd0, 0);
      chk("rst_dout", dout0, 0);
`ifdef LINE_MEM_STATS_EN
      chk("rst_num_reads", nr0, 0);
      chk("rst_num_writes", nw0, 0);
`endif
      reset = 1'b1;
      @(negedge clk);

      // Directed: write then read line 5, wrap-around through 0x105
      issue0(1'b0, 1'b1, 32'h5, a5);
      issue0(1'b1, 1'b0, 32'h5, '0);
      d = rnd_line();
      issue0(1'b0, 1'b1, 32'h105, d);
      issue0(1'b1, 1'b0, 32'h005, '0);

      // Illegal op encodings are no-ops
      for (int i = 0; i < 10; i++) issue0(1'b1, 1'b1, 32'h5, rnd_line());
      issue0(1'b0, 1'b0, 32'h5, rnd_line());
      issue0(1'b1, 1'b0, 32'h105, '0);

      // Reset 20 cycles into a write to line 7: no pulse, array unchanged
      iv0 = 1'b1; rd0 = 1'b0; wr0 = 1'b1; addr0 = 32'h7; din0 = rnd_line();
      @(negedge clk);
      iv0 = 1'b0; wr0 = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", rdy0, 1);
      chk("abort_done", wd0, 0);
      chk("abort_dout", dout0, 0);
`ifdef LINE_MEM_STATS_EN
      chk("abort_num_reads", nr0, 0);
      chk("abort_num_writes", nw0, 0);
`endif
      @(negedge clk);
      reset = 1'b1;
      rd_exp0 = 0; wr_exp0 = 0;
      @(negedge clk);
      issue0(1'b1, 1'b0, 32'h7, '0);
      issue0(1'b1, 1'b0, 32'h5, '0);

      // Random traffic on the LATENCY=50 instance
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 9);
         if (op < 4)      issue0(1'b0, 1'b1, 32'($urandom_range(0, 7)) + 32'($urandom_range(0, 3)) * 256, rnd_line());
         else if (op < 8) issue0(1'b1, 1'b0, 32'($urandom_range(0, 7)) + 32'($urandom_range(0, 3)) * 256, '0);
         else if (op == 8) issue0(1'b1, 1'b1, $urandom, rnd_line());
         else             issue0(1'b0, 1'b0, $urandom, rnd_line());
      end

      // LATENCY=1 instance: back-to-back traffic, reads often hit fresh writes
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 9);
         if (op < 4)      issue1(1'b0, 1'b1, $urandom, rnd_line());
         else if (op < 9) issue1(1'b1, 1'b0, $urandom, '0);
         else             issue1(1'b1, 1'b1, $urandom, rnd_line());
      end

      repeat (5) @(negedge clk);
      chk("queue0_empty", q0.size(), 0);
      chk("queue1_empty", q1.size(), 0);
`ifdef LINE_MEM_STATS_EN
      chk("num_reads0", nr0, rd_exp0);
      chk("num_writes0", nw0, wr_exp0);
      chk("num_reads1", nr1, rd_exp1);
      chk("num_writes1", nw1, wr_exp1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
